// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared FSM encodings and Funct3 size constants for the load/store unit
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mau_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Any encoding not explicitly byte or half falls back to a word access.
    function automatic mau_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - selects the addressed byte/half of a read word and extends it
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (addr)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

        case (f3_size(funct3))
            SZ_BYTE: data = funct3[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF: data = funct3[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with lane steering, stall and bus timeout
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignedM,
    output logic        BusErrM
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mau_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic        req_q, we_q, err_q;
    logic [31:0] addr_q, wdata_q, rd_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        is_access, misaligned, start;
    mau_size_e   size;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_data;

    assign is_access = MemWriteM || (ResultSrcM == 2'b01);
    assign size      = f3_size(Funct3M);

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = WriteDataM;
        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            SZ_HALF: begin
                misaligned = ALUResultM[0];
                be_d       = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_d    = {2{WriteDataM[15:0]}};
            end
            default: misaligned = (ALUResultM[1:0] != 2'b00);
        endcase
    end

    assign start = (state_q == ST_IDLE) && is_access && !flush && !misaligned;

    mem_load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (off_q),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_REQ;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM;
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        wdata_q <= MemWriteM ? wdata_d : 32'h0;
                        be_q    <= be_d;
                        f3_q    <= Funct3M;
                        off_q   <= ALUResultM[1:0];
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Bus-facing fields return to zero as soon as the request drops.
                    if (mem_ready || cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        be_q    <= '0;
                    end
                    if (mem_ready) begin
                        state_q <= we_q ? ST_DONE : ST_WAIT;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        err_q   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mem_rvalid) begin
                        state_q <= ST_DONE;
                        rd_q    <= load_data;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_q    <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign ReadDataM = rd_q;
    assign BusErrM   = err_q;

    // The IDLE-cycle stall and fault pulse are combinational; gate them so reset forces them low.
    assign StallM      = rst_n && (start || state_q == ST_REQ || state_q == ST_WAIT);
    assign MisalignedM = rst_n && (state_q == ST_IDLE) && is_access && !flush && misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignedM, BusErrM;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .ResultSrcM  (ResultSrcM),
        .MemWriteM   (MemWriteM),
        .Funct3M     (Funct3M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .StallM      (StallM),
        .ReadDataM   (ReadDataM),
        .MisalignedM (MisalignedM),
        .BusErrM     (BusErrM)
    );

    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        flush      = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        #12;
        n_checks++;
        if ({mem_req, mem_we, StallM, MisalignedM, BusErrM} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {mem_req, mem_we, StallM, MisalignedM, BusErrM});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, mem_be, ReadDataM} !== 100'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h be %b rd %h required all zero", mem_addr, mem_wdata, mem_be, ReadDataM);
        end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_store_sb;
        next_cycle();
        MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h103; WriteDataM = 32'hAB; mem_ready = 1'b1;
        #3;
        n_checks++;
        if (StallM !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_idle: stall %b req %b required 1 0", StallM, mem_req);
        end
        next_cycle();
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_req_ctrl: req %b we %b stall %b required 1 1 1", mem_req, mem_we, StallM);
        end
        n_checks++;
        if (mem_be !== 4'b1000 || mem_wdata !== 32'hABABABAB || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL sb_lanes: be %b wdata %h addr %h required 1000 ababab ab 00000100", mem_be, mem_wdata, mem_addr);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (StallM !== 1'b0 || mem_req !== 1'b0 || mem_be !== 4'b0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done: stall %b req %b be %b wdata %h we %b required all zero", StallM, mem_req, mem_be, mem_wdata, mem_we);
        end
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp, input string name);
        next_cycle();
        ResultSrcM = 2'b01; Funct3M = f3; ALUResultM = addr; mem_ready = 1'b1;
        #3;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_stall: got %b required 1", name, StallM);
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {addr[31:2], 2'b00}) begin
            n_fail++;
            $display("FAIL %s_req: req %b we %b addr %h required 1 0 %h", name, mem_req, mem_we, mem_addr, {addr[31:2], 2'b00});
        end
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #3;
        n_checks++;
        if (StallM !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_wait: stall %b req %b required 1 0", name, StallM, mem_req);
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (ReadDataM !== exp || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: rd %h stall %b required %h 0", name, ReadDataM, StallM, exp);
        end
    endtask

    task automatic test_load_extension;
        run_load(3'b000, 32'h102, 32'h00800000, 32'hFFFFFF80, "lb");
        run_load(3'b100, 32'h102, 32'h00800000, 32'h00000080, "lbu");
        run_load(3'b000, 32'h101, 32'h00007F00, 32'h0000007F, "lb_pos");
        run_load(3'b001, 32'h102, 32'h80010000, 32'hFFFF8001, "lh");
        run_load(3'b101, 32'h102, 32'h80010000, 32'h00008001, "lhu");
        run_load(3'b010, 32'h100, 32'h89ABCDEF, 32'h89ABCDEF, "lw");
        run_load(3'b111, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, "f3_other");
    endtask

    task automatic test_misaligned;
        next_cycle();
        ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h006;
        #3;
        n_checks++;
        if (MisalignedM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misaligned: mis %b stall %b req %b required 1 0 0", MisalignedM, StallM, mem_req);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (MisalignedM !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misaligned_after: mis %b req %b required 0 0", MisalignedM, mem_req);
        end
        next_cycle();
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h201; WriteDataM = 32'h55;
        #3;
        n_checks++;
        if (MisalignedM !== 1'b1 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_misaligned: mis %b stall %b required 1 0", MisalignedM, StallM);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || MisalignedM !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_misaligned_after: req %b mis %b required 0 0", mem_req, MisalignedM);
        end
    endtask

    task automatic test_timeout;
        next_cycle();
        ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h40;
        #3;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
            #3;
            n_checks++;
            if (mem_req !== 1'b1 || StallM !== 1'b1 || BusErrM !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_req%0d: req %b stall %b err %b required 1 1 0", i, mem_req, StallM, BusErrM);
            end
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (BusErrM !== 1'b1 || ReadDataM !== 32'h0 || mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_done: err %b rd %h req %b stall %b required 1 0 0 0", BusErrM, ReadDataM, mem_req, StallM);
        end
        next_cycle();
        #3;
        n_checks++;
        if (BusErrM !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: err %b required 0", BusErrM);
        end
    endtask

    task automatic test_reset_in_wait;
        next_cycle();
        ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h20; mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        mem_ready = 1'b0;
        #3;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_pre: stall %b required 1", StallM);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, StallM, MisalignedM, BusErrM} !== 5'b0
            || {mem_addr, mem_wdata, mem_be, ReadDataM} !== 100'b0) begin
            n_fail++;
            $display("FAIL rst_async: req %b stall %b addr %h be %b rd %h required all zero", mem_req, StallM, mem_addr, mem_be, ReadDataM);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        next_cycle();
        MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h202; WriteDataM = 32'h1234; mem_ready = 1'b1;
        #3;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_after_rst_idle: stall %b required 1", StallM);
        end
        next_cycle();
        #3;
        n_checks++;
        if (mem_be !== 4'b1100 || mem_wdata !== 32'h12341234 || mem_addr !== 32'h200 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_after_rst_req: be %b wdata %h addr %h req %b required 1100 12341234 00000200 1", mem_be, mem_wdata, mem_addr, mem_req);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_after_rst_done: req %b stall %b required 0 0", mem_req, StallM);
        end
    endtask

    task automatic test_flush;
        next_cycle();
        ResultSrcM = 2'b01; Funct3M = 3'b010; ALUResultM = 32'h30; flush = 1'b1; mem_ready = 1'b1;
        #3;
        n_checks++;
        if (StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_stall: got %b required 0", StallM);
        end
        next_cycle();
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_req: req %b stall %b required 0 0", mem_req, StallM);
        end
        flush = 1'b0;
        next_cycle();
        flush = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_req: req %b required 1", mem_req);
        end
        next_cycle();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
        #3;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_wait: stall %b required 1", StallM);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (ReadDataM !== 32'h13579BDF || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: rd %h stall %b required 13579bdf 0", ReadDataM, StallM);
        end
    endtask

    task automatic test_back_to_back;
        next_cycle();
        MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h300; WriteDataM = 32'hDEADBEEF; mem_ready = 1'b1;
        next_cycle();
        #3;
        n_checks++;
        if (mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL sw_req: be %b wdata %h addr %h required 1111 deadbeef 00000300", mem_be, mem_wdata, mem_addr);
        end
        next_cycle();
        Funct3M = 3'b000; ALUResultM = 32'h301; WriteDataM = 32'h5A;
        #3;
        n_checks++;
        if (StallM !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: stall %b req %b required 0 0", StallM, mem_req);
        end
        next_cycle();
        #3;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: stall %b required 1", StallM);
        end
        next_cycle();
        #3;
        n_checks++;
        if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A || mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL b2b_sb_req: be %b wdata %h addr %h required 0010 5a5a5a5a 00000300", mem_be, mem_wdata, mem_addr);
        end
        next_cycle();
        clear_inputs();
        #3;
        n_checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sb_done: req %b stall %b required 0 0", mem_req, StallM);
        end
    endtask

    initial begin
        test_reset();
        test_store_sb();
        test_load_extension();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_flush();
        test_back_to_back();
        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
